// File: rtl/col_sel_seq.sv
// Column-select sequencer: four loadable column banks stepped onto a 4:1 mux select,
// each slot held for a programmable number of accepted beats.
module col_sel_seq #(
   parameter int COL    = 3,
   parameter int HOLD_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load_en,
   input  logic [1:0]        i_load_idx,
   input  logic [COL-1:0]    i_load_data,
   input  logic              i_start,
   input  logic [HOLD_W-1:0] i_hold,
   input  logic              i_ready,
   output logic [COL-1:0]    o_data1,
   output logic [COL-1:0]    o_data2,
   output logic [COL-1:0]    o_data3,
   output logic [COL-1:0]    o_data4,
   output logic [1:0]        o_sel,
   output logic              o_valid,
   output logic              o_busy,
   output logic              o_done
);

   // state | meaning
   // IDLE  | banks writable, waiting for start
   // RUN   | presenting beats, stepping o_sel 0..3
   // DONE  | one-cycle completion pulse, then back to IDLE
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [COL-1:0]    bank_q [4];
   logic [COL-1:0]    bank_d [4];
   logic [1:0]        sel_q, sel_d;
   logic [HOLD_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      beat_cnt_d = beat_cnt_q;
      hold_d     = hold_q;
      for (int i = 0; i < 4; i++) bank_d[i] = bank_q[i];

      case (state_q)
         ST_IDLE: begin
            if (i_load_en) bank_d[i_load_idx] = i_load_data;
            if (i_start) begin
               hold_d     = i_hold;
               sel_d      = 2'd0;
               beat_cnt_d = '0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            // o_valid is always high here, so i_ready alone marks an accepted beat
            if (i_ready) begin
               if (beat_cnt_q < hold_q) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end else if (sel_q != 2'd3) begin
                  sel_d      = sel_q + 1'b1;
                  beat_cnt_d = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            sel_d      = 2'd0;
            beat_cnt_d = '0;
         end
         default: begin
            state_d    = ST_IDLE;
            sel_d      = 2'd0;
            beat_cnt_d = '0;
         end
      endcase

      valid_d = (state_d == ST_RUN);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= 2'd0;
         beat_cnt_q <= '0;
         hold_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < 4; i++) bank_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         beat_cnt_q <= beat_cnt_d;
         hold_q     <= hold_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         for (int i = 0; i < 4; i++) bank_q[i] <= bank_d[i];
      end
   end

   assign o_data1 = bank_q[0];
   assign o_data2 = bank_q[1];
   assign o_data3 = bank_q[2];
   assign o_data4 = bank_q[3];
   assign o_sel   = sel_q;
   assign o_valid = valid_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_col_sel_seq.sv
// Bench for col_sel_seq: expected beat stream is queued per sequence from the bank model,
// and a negedge monitor pops and compares every accepted beat and each done pulse.
module tb_col_sel_seq;
   localparam int COL    = 3;
   localparam int HOLD_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_load_en = 1'b0;
   logic [1:0]        i_load_idx = '0;
   logic [COL-1:0]    i_load_data = '0;
   logic              i_start = 1'b0;
   logic [HOLD_W-1:0] i_hold = '0;
   logic              i_ready = 1'b0;
   logic [COL-1:0]    o_data1, o_data2, o_data3, o_data4;
   logic [1:0]        o_sel;
   logic              o_valid, o_busy, o_done;

   col_sel_seq #(.COL(COL), .HOLD_W(HOLD_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_load_en  (i_load_en),
      .i_load_idx (i_load_idx),
      .i_load_data(i_load_data),
      .i_start    (i_start),
      .i_hold     (i_hold),
      .i_ready    (i_ready),
      .o_data1    (o_data1),
      .o_data2    (o_data2),
      .o_data3    (o_data3),
      .o_data4    (o_data4),
      .o_sel      (o_sel),
      .o_valid    (o_valid),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sel;
      int data;
      int beat;
   } beat_t;

   beat_t exp_q[$];
   beat_t e;
   int    mb[4];
   int    n_pass = 0;
   int    n_total = 0;
   int    done_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int bank_out(input int idx);
      case (idx)
         0: return int'(o_data1);
         1: return int'(o_data2);
         2: return int'(o_data3);
         default: return int'(o_data4);
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL extra_beat: got sel %0d expected no beat", o_sel);
            end else begin
               e = exp_q.pop_front();
               chk("beat_sel", int'(o_sel), e.sel);
               chk("beat_data", bank_out(int'(o_sel)), e.data);
               chk("beat_cnt", int'(dut.beat_cnt_q), e.beat);
               chk("beat_busy", int'(o_busy), 1);
            end
         end
         if (o_done) begin
            done_cnt++;
            chk("done_drained", exp_q.size(), 0);
            chk("done_valid", int'(o_valid), 0);
            chk("done_busy", int'(o_busy), 1);
         end
      end
   end

   task automatic load(input int idx, input int data);
      @(posedge clk); #1;
      i_load_en = 1'b1;
      i_load_idx = idx[1:0];
      i_load_data = data[COL-1:0];
      @(posedge clk); #1;
      i_load_en = 1'b0;
      mb[idx] = data & ((1 << COL) - 1);
      chk("load_visible", bank_out(idx), mb[idx]);
   endtask

   // mode 0: ready always high, 1: random ready, 2: stall slot 1 beat 0 for 4 cycles
   task automatic run_seq(input int h, input int mode, input bit inject);
      int cyc, acc, stall, d0;
      bit rdy;
      for (int s = 0; s < 4; s++)
         for (int k = 0; k <= h; k++) exp_q.push_back('{s, mb[s], k});
      d0 = done_cnt; acc = 0; stall = 0; cyc = 0;
      @(posedge clk); #1;
      i_start = 1'b1;
      i_hold = h[HOLD_W-1:0];
      i_ready = 1'b0;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("start_valid", int'(o_valid), 1);
      chk("start_sel", int'(o_sel), 0);
      while (!o_done && cyc < 1000) begin
         case (mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: rdy = !(acc == h + 1 && stall < 4);
         endcase
         if (mode == 2 && !rdy) begin
            stall++;
            chk("stall_sel", int'(o_sel), 1);
            chk("stall_beat", int'(dut.beat_cnt_q), 0);
         end
         if (inject && cyc == 2) begin
            i_start = 1'b1; i_load_en = 1'b1; i_load_idx = 2'd2; i_load_data = 3'd7;
         end else begin
            i_start = 1'b0; i_load_en = 1'b0;
         end
         i_ready = rdy;
         if (rdy) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      i_load_en = 1'b0;
      i_ready = 1'b0;
      i_start = inject;
      if (!o_done) begin
         n_total++;
         $display("FAIL seq_timeout: got no done after %0d cycles expected done", cyc);
      end else begin
         chk("accepts", acc, 4 * (h + 1));
         if (mode == 0) chk("seq_len", cyc, 4 * (h + 1));
         if (mode == 2) chk("stall_cycles", stall, 4);
      end
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("post_busy", int'(o_busy), 0);
      chk("post_sel", int'(o_sel), 0);
      chk("post_valid", int'(o_valid), 0);
      chk("post_done", int'(o_done), 0);
      chk("done_once", done_cnt - d0, 1);
      chk("stream_empty", exp_q.size(), 0);
      if (inject) chk("bank2_frozen", int'(o_data3), mb[2]);
   endtask

   task automatic reset_mid_run();
      int cyc;
      for (int s = 0; s < 4; s++)
         for (int k = 0; k <= 3; k++) exp_q.push_back('{s, mb[s], k});
      @(posedge clk); #1;
      i_start = 1'b1; i_hold = 4'd3; i_ready = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      cyc = 0;
      while (o_sel != 2'd2 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reach_sel2", int'(o_sel), 2);
      rst_n = 1'b0;
      i_ready = 1'b0;
      #1;
      chk("rst_sel", int'(o_sel), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_state", int'(dut.state_q), 0);
      for (int i = 0; i < 4; i++) begin
         chk("rst_bank", bank_out(i), 0);
         mb[i] = 0;
      end
      exp_q.delete();
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_release_busy", int'(o_busy), 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mb[i] = 0;
      #23 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_sel", int'(o_sel), 0);
      chk("reset_valid", int'(o_valid), 0);
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_done", int'(o_done), 0);
      for (int i = 0; i < 4; i++) chk("reset_bank", bank_out(i), 0);

      load(0, 5); load(1, 3); load(2, 6); load(3, 1);
      run_seq(0, 0, 1'b0);
      run_seq(2, 0, 1'b0);
      run_seq(1, 2, 1'b0);
      run_seq(1, 0, 1'b1);
      run_seq(15, 0, 1'b0);
      reset_mid_run();

      for (int n = 0; n < 10; n++) begin
         for (int j = 0; j < 3; j++) load($urandom_range(0, 3), $urandom_range(0, 7));
         run_seq($urandom_range(0, 4), 1, n[0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
